// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate defaults, divider helper, transmit
// state encoding and frame shape. The receiver side imports the same package.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 27_000_000;
    localparam int DEFAULT_BAUD_RATE = 115_200;

    // 8N1 framing
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Clocks per bit; integer division, so the caller must keep the result >= 4.
    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// rdata always shows the head entry while empty is low; pop advances it.
// Pushes while full and pops while empty are ignored, so count stays in range.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_DEPTH);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes enter a FIFO through a valid/ready
// handshake and a bit-timing FSM shifts them out LSB-first with no idle gap
// between queued frames.
//
// Handshake: a byte is transferred on every rising edge where tx_valid and
// tx_ready are both high; tx_data must be stable then. tx_ready does not
// depend on tx_valid, and tx_valid without tx_ready transfers nothing.
//
// The line register tx follows the FSM state one clock later, so the start
// bit appears two edges after a push into an idle, empty block and every
// bit lasts exactly BAUD_DIV clocks.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int BAUD_DIV   = calc_baud_div(CLK_FREQ, BAUD_RATE),
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output tx_state_t                     tx_state
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    tx_state_t            state_q;
    logic [CW-1:0]        baud_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 push;
    logic                 pop;
    logic                 baud_last;

    assign tx_ready  = !reset && !fifo_full;
    assign push      = tx_valid && tx_ready;
    assign baud_last = (baud_q == BAUD_LAST);
    // Load the shifter from idle, or straight out of the last stop clock.
    assign pop       = !fifo_empty &&
                       ((state_q == IDLE) || ((state_q == STOP) && baud_last));

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE) || (fifo_count != '0);
    assign tx_state  = state_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Bit-timing FSM: baud counter, bit counter, shifter and registered line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (pop) begin
                        shift_q <= fifo_rdata;
                        state_q <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_q   <= '0;
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + BIT_ONE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= fifo_rdata;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed steps plus shuffled full-byte loopback.
// A line decoder recovers frames from tx by cycle counting and feeds a
// scoreboard that is compared against the queue of accepted bytes.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int B     = 8;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * B;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;
  tx_state_t  tx_state;

  uart_tx_fifo #(
    .CLK_FREQ   (27000000),
    .BAUD_RATE  (115200),
    .BAUD_DIV   (B),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .tx_state   (tx_state)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         total = 0;
  int         bad = 0;
  int         last_acc;
  int         peak;
  logic       mon_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver: call at a negedge; returns at the negedge after acceptance with tx_valid still high
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
      last_acc = cyc;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) chk("wait_cyc_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy !== 1'b0 && guard < 40000) begin
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      @(negedge clk);
      guard++;
    end
    if (guard >= 40000) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
    repeat (2 * B) @(negedge clk);
  endtask

  task automatic check_sb(input string tag);
    logic [7:0] e;
    logic [7:0] r;
    chk({tag, "_frame_count"}, rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      chk({tag, "_byte"}, r, e);
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  // line decoder: every clock of each bit must equal that bit's first clock
  logic [7:0] mon_byte;
  logic       mon_ok;
  logic       mon_bit;
  logic       mon_ab;
  int         mon_sc;
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_abort && reset === 1'b0 && tx === 1'b0) begin
        mon_sc   = cyc;
        mon_ok   = 1'b1;
        mon_ab   = 1'b0;
        mon_byte = '0;
        mon_bit  = 1'b0;
        for (int k = 0; k < 10 && !mon_ab; k++) begin
          for (int j = 0; j < B && !mon_ab; j++) begin
            if (!(k == 0 && j == 0)) @(negedge clk);
            if (mon_abort) begin
              mon_ab = 1'b1;
            end else if (j == 0) begin
              mon_bit = tx;
            end else if (tx !== mon_bit) begin
              mon_ok = 1'b0;
            end
          end
          if (!mon_ab) begin
            if (k == 0 && mon_bit !== 1'b0) mon_ok = 1'b0;
            if (k >= 1 && k <= 8) mon_byte[k-1] = mon_bit;
            if (k == 9 && mon_bit !== 1'b1) mon_ok = 1'b0;
          end
        end
        if (!mon_ab) begin
          chk("frame_shape", mon_ok, 1'b1);
          rx_q.push_back(mon_byte);
          start_q.push_back(mon_sc);
        end
      end
    end
  end

  logic [7:0] perm [256];
  int         acc0;
  int         n_drop;
  int         rise_cyc;
  int         idx;
  logic       dropped;

  initial begin
    reset     = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    mon_abort = 1'b0;
    peak      = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 5'd0);
    chk("rst_ready", tx_ready, 1'b0);
    chk("rst_state", tx_state, IDLE);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", tx_ready, 1'b1);

    // single byte: start bit two edges after acceptance, busy ends with the frame
    send(8'h31);
    tx_valid = 1'b0;
    acc0 = last_acc;
    wait_cyc(acc0 + FRAME);
    chk("t1_busy_last_stop", busy, 1'b1);
    @(negedge clk);
    chk("t1_busy_fall", busy, 1'b0);
    wait_idle("t1");
    chk("t1_frames", start_q.size(), 1);
    if (start_q.size() >= 1) chk("t1_start_latency", start_q[0] - acc0, 2);
    check_sb("t1");
    start_q.delete();

    // three consecutive pushes: contiguous frames, fifo_count peaks at 2
    peak = 0;
    send(8'h30);
    send(8'h31);
    send(8'h55);
    tx_valid = 1'b0;
    wait_idle("t2");
    chk("t2_peak", peak, 2);
    chk("t2_frames", start_q.size(), 3);
    if (start_q.size() >= 3) begin
      chk("t2_gap01", start_q[1] - start_q[0], FRAME);
      chk("t2_gap12", start_q[2] - start_q[1], FRAME);
      chk("t2_span", start_q[2] + FRAME - start_q[0], 3 * FRAME);
    end
    check_sb("t2");
    start_q.delete();

    // tx_valid held with 20 bytes: 17 accepted before tx_ready drops
    idx      = 0;
    dropped  = 1'b0;
    n_drop   = -1;
    rise_cyc = -1;
    acc0     = 0;
    for (int g = 0; g < 3000 && idx < 20; g++) begin
      tx_data  = 8'(64 + idx);
      tx_valid = 1'b1;
      #1;
      if (tx_ready) begin
        if (dropped && rise_cyc < 0) rise_cyc = cyc;
        @(posedge clk);
        exp_q.push_back(tx_data);
        @(negedge clk);
        if (idx == 0) acc0 = cyc;
        idx++;
      end else begin
        if (!dropped) begin
          dropped = 1'b1;
          n_drop  = idx;
        end
        @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    chk("t3_accepted_before_full", n_drop, 17);
    chk("t3_all_accepted", idx, 20);
    chk("t3_ready_rise", rise_cyc - acc0, 1 + FRAME);
    wait_idle("t3");
    check_sb("t3");
    start_q.delete();

    // push on the same edge as the stop-to-start pop, with 5 queued
    send(8'h01);
    acc0 = last_acc;
    for (int i = 2; i <= 6; i++) send(8'(i * 17));
    tx_valid = 1'b0;
    wait_cyc(acc0 + FRAME);
    chk("t4_count_before", fifo_count, 5'd5);
    send(8'hC4);
    tx_valid = 1'b0;
    chk("t4_count_after", fifo_count, 5'd5);
    chk("t4_push_edge", last_acc - acc0, FRAME + 1);
    wait_idle("t4");
    check_sb("t4");
    start_q.delete();

    // one-clock reset mid-DATA with 4 queued, then a clean 0xA5 frame
    for (int i = 0; i < 5; i++) send(8'(8'hE0 + i));
    tx_valid = 1'b0;
    acc0 = last_acc - 4;
    chk("t5_count_queued", fifo_count, 5'd4);
    wait_cyc(acc0 + 1 + 4 * B + 2);
    chk("t5_busy_mid", busy, 1'b1);
    mon_abort = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_ready_in_reset", tx_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    chk("t5_tx_after_reset", tx, 1'b1);
    chk("t5_count_after_reset", fifo_count, 5'd0);
    chk("t5_busy_after_reset", busy, 1'b0);
    exp_q.delete();
    rx_q.delete();
    repeat (2 * B) @(negedge clk);
    chk("t5_line_stays_high", tx, 1'b1);
    start_q.delete();
    mon_abort = 1'b0;
    @(negedge clk);
    send(8'hA5);
    tx_valid = 1'b0;
    wait_idle("t5");
    check_sb("t5");
    start_q.delete();

    // all 256 values in shuffled order with random producer gaps
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [7:0] t;
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      send(perm[i]);
      if ($urandom_range(3, 0) == 0) begin
        tx_valid = 1'b0;
        repeat ($urandom_range(40, 1)) @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    wait_idle("t6");
    chk("t6_count_idle", fifo_count, 5'd0);
    check_sb("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter, the send-side companion of the team's UART receiver on the Tang Nano 9K, and the upstream stage that drives a receiver's rx pin. Bytes are pushed through a valid/ready handshake into an internal FIFO. A bit-timing state machine serialises them LSB-first onto `tx` with no idle gap between queued frames. The bench uses it to produce host-side stimulus, and the board uses it for echo/status replies.

## Interface
- `CLK_FREQ`, 27000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate.
- `BAUD_DIV`, CLK_FREQ/BAUD_RATE (integer divide, 234 at defaults): clocks per bit; must be ≥ 4.
- `FIFO_DEPTH`, 16: byte entries; power of two, 2..256.
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `tx_data` in 8: byte to send; sampled when `tx_valid && tx_ready`.
- `tx_valid` in 1: producer has a byte.
- `tx_ready` out 1: FIFO can accept a byte this cycle.
- `tx` out 1: serial line, idle high, registered.
- `busy` out 1: a frame is in progress or the FIFO is non-empty.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: bytes currently queued, excluding the byte in the shifter.

## Operation
- Push: on a cycle with `tx_valid && tx_ready`, `tx_data` is written to the FIFO tail and `fifo_count` increments on that edge.
- `tx_ready` = !reset && (fifo_count != FIFO_DEPTH).
- Holding `tx_valid` high while `tx_ready` is low has no effect; data is not captured.
- FSM states and transitions:
  - IDLE: when the FIFO is non-empty, pop the head into an 8-bit shifter and go to START.
  - START: `tx`=0 for BAUD_DIV clocks, then go to DATA.
  - DATA: drive shifter bit 0 for BAUD_DIV clocks, shift right, 8 bits total, bit counter 0..7, then go to STOP.
  - STOP: `tx`=1 for BAUD_DIV clocks. On the last stop clock, if the FIFO is non-empty, pop and go to START with a zero-gap start bit; otherwise go to IDLE.
- Baud counter counts 0..BAUD_DIV-1 and wraps; it is cleared on every state entry.
- Push and pop on the same edge: both take effect and `fifo_count` is unchanged.
  - When full, only the pop occurs, because `tx_ready` was low.
  - When empty, no pop occurs; the pushed byte is popped on a later cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. `fifo_count` never exceeds FIFO_DEPTH and never underflows.
- `busy` = (state != IDLE) || (fifo_count != 0).
- Reset, including mid-frame, takes effect on the next edge:
  - state=IDLE, `tx`=1, pointers and `fifo_count`=0, `busy`=0, `tx_ready`=0 while `reset` is held.
  - Queued and in-flight bytes are discarded.
  - The partially sent frame is abandoned with the line high.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `tx_ready`=0 during reset and 1 on the first cycle after.
- Latency from an accepted push at edge N into an empty, idle block:
  - pop at edge N+1;
  - `tx` falls at edge N+2;
  - frame ends 10×BAUD_DIV clocks later (2340 at defaults).
- Every bit period is exactly BAUD_DIV clocks; there is no cumulative drift.
- Back-to-back frames: the next start bit begins on the clock immediately after the last stop-bit clock.
- Capacity: FIFO_DEPTH queued bytes plus 1 in the shifter.

## Structure
- Shared package `uart_pkg`:
  - default CLK_FREQ and BAUD_RATE;
  - BAUD_DIV computation function;
  - tx state enum (IDLE, START, DATA, STOP);
  - frame constants (DATA_BITS=8, STOP_BITS=1).
  - The receiver side uses the same package.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH):
  - ports: push, pop, wdata, rdata (first-word-fall-through), full, empty, count;
  - reset synchronous, active-high.
- The FSM, baud counter and shifter live in `uart_tx_fifo`.

## Test plan
- Single byte 0x31 after reset: `tx` low 234 clocks, then bits 1,0,0,0,1,1,0,0 at 234 clocks each, then high 234 clocks. `busy` falls on the cycle after the stop bit ends.
- Bytes 0x30, 0x31, 0x55 pushed on consecutive cycles: three contiguous frames totalling 7020 clocks with no idle clocks between them. `fifo_count` peaks at 2.
- `tx_valid` held high with 20 incrementing bytes while idle: exactly 17 accepted before `tx_ready` drops. `tx_ready` re-asserts one clock after the next pop. Output byte order matches input.
- Push on the same edge as the STOP-to-START pop with `fifo_count`=5: `fifo_count` stays 5 and no byte is lost or duplicated.
- `reset` pulsed for 1 clock mid-DATA with 4 bytes queued: next edge shows `tx`=1, `fifo_count`=0, `busy`=0. A new byte 0xA5 then frames correctly.
- Loopback into the team's receiver (BAUD_DIV=234), sending all 256 byte values: every byte is received intact with a valid stop bit.
